// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 burst master: turns one command into a classic cycle or an
// incrementing (linear / wrap-4/8/16) burst, streaming write data in and
// read data out, and reports completion or bus error.
module wb_b3_burst_master #(
   parameter int aw = 32,
   parameter int dw = 32
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   // command
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic          cmd_we_i,
   input  logic [aw-1:0] cmd_adr_i,
   input  logic [3:0]    cmd_len_i,
   input  logic [1:0]    cmd_bte_i,
   // write stream
   input  logic [dw-1:0] wdat_i,
   input  logic          wvalid_i,
   output logic          wready_o,
   // read stream / status
   output logic [dw-1:0] rdat_o,
   output logic          rvalid_o,
   output logic          done_o,
   output logic          err_o,
   // wishbone master
   output logic [aw-1:0] wb_adr_o,
   output logic [dw-1:0] wb_dat_o,
   output logic [3:0]    wb_sel_o,
   output logic          wb_we_o,
   output logic [2:0]    wb_cti_o,
   output logic [1:0]    wb_bte_o,
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   input  logic [dw-1:0] wb_dat_i,
   input  logic          wb_ack_i,
   input  logic          wb_err_i,
   input  logic          wb_rty_i
);

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   typedef enum logic {IDLE, BUS} state_t;

   state_t        state;
   logic [3:0]    cnt;        // beats remaining after the current one
   logic          bus_err;
   logic [aw-1:0] adr_inc;
   logic [aw-1:0] wrap_mask;
   logic [aw-1:0] adr_next;
   logic          unused_adr_lsb;

   // retry is handled exactly like an error
   assign bus_err = (state == BUS) & (wb_err_i | wb_rty_i);

   assign cmd_ready_o = (state == IDLE);
   assign wb_stb_o    = wb_cyc_o & (~wb_we_o | wvalid_i);
   assign wready_o    = (state == BUS) & wb_we_o & wb_ack_i;
   assign wb_dat_o    = wdat_i;
   assign wb_sel_o    = 4'hf;

   assign unused_adr_lsb = ^cmd_adr_i[1:0];

   // next beat address: bits inside the wrap mask take the incremented
   // value, bits outside are held; linear uses an all-ones mask
   always_comb begin
      adr_inc = wb_adr_o + aw'(4);
      case (wb_bte_o)
         2'b01:   wrap_mask = aw'(32'h0000_000c);
         2'b10:   wrap_mask = aw'(32'h0000_001c);
         2'b11:   wrap_mask = aw'(32'h0000_003c);
         default: wrap_mask = '1;
      endcase
      adr_next = (wb_adr_o & ~wrap_mask) | (adr_inc & wrap_mask);
   end

   // command accept, beat sequencing and completion reporting
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state    <= IDLE;
         cnt      <= '0;
         wb_cyc_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wb_adr_o <= '0;
         wb_cti_o <= CTI_CLASSIC;
         wb_bte_o <= 2'b00;
         rdat_o   <= '0;
         rvalid_o <= 1'b0;
         done_o   <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         rvalid_o <= 1'b0;
         done_o   <= 1'b0;
         err_o    <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid_i) begin
                  state    <= BUS;
                  wb_cyc_o <= 1'b1;
                  wb_we_o  <= cmd_we_i;
                  wb_adr_o <= {cmd_adr_i[aw-1:2], 2'b00};
                  wb_bte_o <= cmd_bte_i;
                  cnt      <= cmd_len_i;
                  wb_cti_o <= (cmd_len_i == 4'd0) ? CTI_CLASSIC : CTI_INCR;
               end
            end
            BUS: begin
               if (bus_err) begin
                  // abandon the rest; the errored beat delivers nothing
                  state    <= IDLE;
                  wb_cyc_o <= 1'b0;
                  wb_cti_o <= CTI_CLASSIC;
                  done_o   <= 1'b1;
                  err_o    <= 1'b1;
               end else if (wb_ack_i) begin
                  if (!wb_we_o) begin
                     rdat_o   <= wb_dat_i;
                     rvalid_o <= 1'b1;
                  end
                  if (cnt == 4'd0) begin
                     state    <= IDLE;
                     wb_cyc_o <= 1'b0;
                     wb_cti_o <= CTI_CLASSIC;
                     done_o   <= 1'b1;
                  end else begin
                     cnt      <= cnt - 4'd1;
                     wb_adr_o <= adr_next;
                     wb_cti_o <= (cnt == 4'd1) ? CTI_EOB : CTI_INCR;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Self-checking bench for wb_b3_burst_master: a RAM slave with random wait
// states (error above 0x1000), a write-stream driver, and a scoreboard fed
// by a beat-list reference model.
module tb_wb_b3_burst_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
   logic [31:0] cmd_adr = '0;
   logic [3:0]  cmd_len = '0;
   logic [1:0]  cmd_bte = '0;
   logic [31:0] wdat = '0;
   logic        wvalid = 1'b0, wready;
   logic [31:0] rdat;
   logic        rvalid, done, err;
   logic [31:0] wb_adr, wb_dat_m, s_dat = '0;
   logic [3:0]  wb_sel;
   logic        wb_we, wb_cyc, wb_stb;
   logic [2:0]  wb_cti;
   logic [1:0]  wb_bte;
   logic        s_ack = 1'b0, s_err = 1'b0;
   logic        s_rty = 1'b0;

   always #5 clk = ~clk;

   wb_b3_burst_master #(.aw(32), .dw(32)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
      .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len), .cmd_bte_i(cmd_bte),
      .wdat_i(wdat), .wvalid_i(wvalid), .wready_o(wready),
      .rdat_o(rdat), .rvalid_o(rvalid), .done_o(done), .err_o(err),
      .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_m), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
      .wb_cti_o(wb_cti), .wb_bte_o(wb_bte), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
      .wb_dat_i(s_dat), .wb_ack_i(s_ack), .wb_err_i(s_err), .wb_rty_i(s_rty)
   );

   typedef struct {
      logic [31:0] adr;
      logic [2:0]  cti;
      logic [1:0]  bte;
      logic        we;
      logic [31:0] dat;
      logic        err;
   } beat_t;

   beat_t       q_bus[$];
   logic [31:0] q_rd[$];
   logic        q_done[$];
   logic [31:0] mem    [0:1023];
   logic [31:0] refmem [0:1023];
   logic [31:0] wq[$];
   int          total = 0, bad = 0;
   int          widx = 0, stall_left = 0, stall_beat = -1, stall_n = 0;
   bit          pend = 0;
   logic [31:0] stall_adr = '0;
   int          stall_cnt = 0, wr_cnt = 0, acks = 0;
   beat_t       mb;
   logic        err_seen = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]    = (i * 32'h9e37_79b9) ^ 32'h5a5a_0000;
         refmem[i] = (i * 32'h9e37_79b9) ^ 32'h5a5a_0000;
      end
   end

   // RAM slave: random wait states, one ack per beat, error out of range
   always @(posedge clk) begin
      if (rst) begin
         s_ack <= 1'b0;
         s_err <= 1'b0;
      end else begin
         s_ack <= 1'b0;
         s_err <= 1'b0;
         if (wb_cyc && wb_stb && !s_ack && !s_err && $urandom_range(0, 3) != 0) begin
            if (wb_adr >= 32'h1000) s_err <= 1'b1;
            else begin
               s_ack <= 1'b1;
               if (wb_we) mem[wb_adr[11:2]] <= wb_dat_m;
               else       s_dat <= mem[wb_adr[11:2]];
            end
         end
      end
   end

   // write-stream source with an optional stall before one beat
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (pend) begin
            pend   = 0;
            widx++;
            wvalid = 1'b0;
            if (widx == stall_beat) stall_left = stall_n;
         end
         if (!wvalid && widx < wq.size()) begin
            if (stall_left > 0) stall_left--;
            else begin
               wvalid = 1'b1;
               wdat   = wq[widx];
            end
         end else if (wvalid && wready) pend = 1;
      end
   end

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (err_seen) chk("cyc_after_err", {31'd0, wb_cyc}, 32'd0);
         err_seen = wb_cyc && wb_stb && s_err;
         if (wb_cyc && wb_stb && (s_ack || s_err)) begin
            acks++;
            if (q_bus.size() == 0) begin
               total++; bad++;
               $display("FAIL bus_beat: unexpected beat at %h", wb_adr);
            end else begin
               mb = q_bus.pop_front();
               chk("beat_adr", wb_adr, mb.adr);
               chk("beat_cti", {29'd0, wb_cti}, {29'd0, mb.cti});
               chk("beat_bte", {30'd0, wb_bte}, {30'd0, mb.bte});
               chk("beat_we",  {31'd0, wb_we},  {31'd0, mb.we});
               chk("beat_err", {31'd0, s_err},  {31'd0, mb.err});
               if (mb.we && !mb.err) chk("beat_wdat", wb_dat_m, mb.dat);
            end
         end
         if (rvalid) begin
            if (q_rd.size() == 0) begin
               total++; bad++;
               $display("FAIL rvalid: unexpected word %h", rdat);
            end else chk("rdat", rdat, q_rd.pop_front());
         end
         if (done) begin
            if (q_done.size() == 0) begin
               total++; bad++;
               $display("FAIL done: unexpected pulse err=%0b", err);
            end else chk("done_err", {31'd0, err}, {31'd0, q_done.pop_front()});
         end else if (err) begin
            total++; bad++;
            $display("FAIL err_alone: err_o=1 want 0 without done_o");
         end
         if (wb_cyc && wb_we && !wb_stb) begin
            stall_cnt++;
            chk("stall_adr", wb_adr, stall_adr);
         end
         if (wready) wr_cnt++;
      end
   end

   task automatic flush_wr();
      wq.delete();
      widx = 0; pend = 0; stall_left = 0; wvalid = 1'b0;
   endtask

   // reference model: beat list from start address, length and wrap size
   task automatic plan_cmd(input logic we, input logic [31:0] adr, input logic [3:0] len,
                           input logic [1:0] bte, input int sbeat, input int sn, output bit term);
      logic [31:0] base, m, a;
      beat_t b;
      int n;
      base = {adr[31:2], 2'b00};
      n    = int'(len) + 1;
      m    = (bte == 2'd1) ? 32'hc : (bte == 2'd2) ? 32'h1c : (bte == 2'd3) ? 32'h3c : 32'hffff_ffff;
      term = 0;
      flush_wr();
      stall_beat = sbeat; stall_n = sn; stall_cnt = 0; wr_cnt = 0;
      for (int i = 0; i < n && !term; i++) begin
         a     = (base & ~m) | ((base + 32'(4 * i)) & m);
         b.adr = a;
         b.cti = (len == 4'd0) ? 3'b000 : (i == n - 1) ? 3'b111 : 3'b010;
         b.bte = bte;
         b.we  = we;
         b.err = (a >= 32'h1000);
         b.dat = '0;
         if (i == sbeat) stall_adr = a;
         if (b.err) term = 1;
         else if (we) begin
            b.dat = $urandom;
            refmem[a[11:2]] = b.dat;
         end else q_rd.push_back(refmem[a[11:2]]);
         if (we) wq.push_back(b.dat);
         q_bus.push_back(b);
      end
      q_done.push_back(term);
   endtask

   task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] len, input logic [1:0] bte);
      step();
      chk("cmd_ready", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_bte = bte;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [3:0] len,
                          input logic [1:0] bte, input int sbeat, input int sn);
      bit term;
      int t, nb;
      plan_cmd(we, adr, len, bte, sbeat, sn, term);
      nb = q_bus.size();
      issue(we, adr, len, bte);
      t = 0;
      while ((q_done.size() != 0 || q_rd.size() != 0 || q_bus.size() != 0) && t < 600) begin
         step();
         t++;
      end
      if (t >= 600) begin
         total++; bad++;
         $display("FAIL timeout: cmd at %h still pending after %0d cycles", adr, t);
         q_done.delete(); q_rd.delete(); q_bus.delete();
      end
      step();
      chk("ready_after", {31'd0, cmd_ready}, 32'd1);
      if (we && !term) begin
         chk("wready_count", wr_cnt, nb);
         chk("stall_cycles", stall_cnt, sn);
      end
      flush_wr();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          term;
      int          t, a0;
      logic        we;
      logic [31:0] adr;
      logic [3:0]  len;
      logic [1:0]  bte;
      int          sb, sn;

      repeat (3) step();
      rst = 1'b0;
      step();
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_cyc", {31'd0, wb_cyc}, 32'd0);
      chk("rst_stb", {31'd0, wb_stb}, 32'd0);
      chk("rst_adr", wb_adr, 32'd0);
      chk("rst_cti", {29'd0, wb_cti}, 32'd0);
      chk("rst_bte", {30'd0, wb_bte}, 32'd0);
      chk("rst_we",  {31'd0, wb_we}, 32'd0);
      chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
      chk("rst_rdat", rdat, 32'd0);
      chk("rst_done", {30'd0, done, err}, 32'd0);
      chk("sel", {28'd0, wb_sel}, 32'hf);

      run_cmd(1'b0, 32'h40,  4'd0, 2'b00, -1, 0);   // single classic read
      run_cmd(1'b0, 32'h100, 4'd3, 2'b00, -1, 0);   // 4-beat linear read
      run_cmd(1'b1, 32'h14,  4'd7, 2'b10, -1, 0);   // wrap-8 write
      run_cmd(1'b0, 32'h0,   4'd7, 2'b00, -1, 0);   // read back the wrap block
      run_cmd(1'b1, 32'h300, 4'd5, 2'b00, 2, 3);    // write with 3-cycle stall
      run_cmd(1'b0, 32'h300, 4'd5, 2'b00, -1, 0);
      run_cmd(1'b0, 32'hff8, 4'd15, 2'b00, -1, 0);  // error on third beat

      // reset during beat 5 of an 8-beat write
      plan_cmd(1'b1, 32'he00, 4'd7, 2'b00, -1, 0, term);
      a0 = acks;
      issue(1'b1, 32'he00, 4'd7, 2'b00);
      t = 0;
      while (acks - a0 < 4 && t < 400) begin
         step();
         t++;
      end
      if (t >= 400) begin
         total++; bad++;
         $display("FAIL timeout: reset test saw %0d acks", acks - a0);
      end
      step();
      rst = 1'b1;
      step();
      chk("mid_rst_cyc", {31'd0, wb_cyc}, 32'd0);
      chk("mid_rst_stb", {31'd0, wb_stb}, 32'd0);
      chk("mid_rst_adr", wb_adr, 32'd0);
      chk("mid_rst_cti", {29'd0, wb_cti}, 32'd0);
      chk("mid_rst_we",  {31'd0, wb_we}, 32'd0);
      chk("mid_rst_done", {30'd0, done, err}, 32'd0);
      q_bus.delete(); q_rd.delete(); q_done.delete();
      flush_wr();
      rst = 1'b0;
      repeat (4) step();
      chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
      run_cmd(1'b1, 32'h200, 4'd3, 2'b00, -1, 0);
      run_cmd(1'b0, 32'h200, 4'd3, 2'b00, -1, 0);

      // randomized commands within the slave's valid range
      for (int k = 0; k < 30; k++) begin
         we  = 1'($urandom_range(0, 1));
         bte = 2'($urandom_range(0, 3));
         len = 4'($urandom_range(0, 15));
         adr = (bte == 2'b00) ? 32'($urandom_range(0, 32'hd00)) : 32'($urandom_range(0, 32'hdff));
         sb  = -1;
         sn  = 0;
         if (we && len >= 4'd2 && $urandom_range(0, 1) == 1) begin
            sb = $urandom_range(1, int'(len));
            sn = $urandom_range(1, 4);
         end
         run_cmd(we, adr, len, bte, sb, sn);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
